// File: rtl/iopmp_cfg_master_if.sv
// Command/response port of the IOPMP configuration initiator.
// The TEE-side requester uses the master modport; the initiator uses slave.
interface iopmp_cfg_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_id;
  logic [1:0]  cmd_md_idx;
  logic [11:0] cmd_reg_addr;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_id, cmd_md_idx, cmd_reg_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_id, cmd_md_idx, cmd_reg_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/iopmp_cfg_master.sv
// IOPMP configuration initiator: turns one command at a time into the checker's
// SRCMD half-word write pair or a single memory-domain register write, with an
// optional read-back verify, then returns a status response.
module iopmp_cfg_master #(
  parameter int unsigned SRCMD_NUM  = 2,
  parameter int unsigned MD_NUM     = 4,
  parameter int unsigned VERIFY_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  iopmp_cfg_master_if.slave cfg,
  output logic              cfg_busy,
  output logic [31:0]       SRCMD_Update_ID,
  output logic              SRCMD_Update_Valid,
  output logic              SRCMD_MS32bit,
  output logic [31:0]       Config_Data,
  output logic [31:0]       iopmp_update_Memory_Domain_data,
  output logic              iopmp_Memory_Domain_wen,
  output logic [11:0]       iopmp_Memory_Domain_Reg_Addr,
  output logic [MD_NUM-1:0] iopmp_md_sel,
  input  logic [31:0]       iopmp_entry_data
);

  typedef enum logic [2:0] {
    StIdle,
    StSrcLo,
    StSrcHi,
    StMdWr,
    StMdWait,
    StMdChk,
    StRsp
  } state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [63:0] data_q;
  logic [3:0]  wait_cnt_q;
  logic        cmd_illegal;

  assign cfg.cmd_ready = (state_q == StIdle) && rst_n;

  // Decode whether the offered command can be executed at all.
  always_comb begin
    cmd_illegal = 1'b0;
    case (cfg.cmd_op)
      2'b00:        cmd_illegal = (32'(cfg.cmd_id) >= SRCMD_NUM);
      2'b01, 2'b10: cmd_illegal = (32'(cfg.cmd_md_idx) >= MD_NUM);
      default:      cmd_illegal = 1'b1;
    endcase
  end

  // Sequencer; every checker-facing and response output is a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                         <= StIdle;
      op_q                            <= 2'b00;
      data_q                          <= 64'h0;
      wait_cnt_q                      <= 4'h0;
      cfg.rsp_valid                   <= 1'b0;
      cfg.rsp_err                     <= 1'b0;
      cfg.rsp_rdata                   <= 32'h0;
      cfg_busy                        <= 1'b0;
      SRCMD_Update_ID                 <= 32'h0;
      SRCMD_Update_Valid              <= 1'b0;
      SRCMD_MS32bit                   <= 1'b0;
      Config_Data                     <= 32'h0;
      iopmp_update_Memory_Domain_data <= 32'h0;
      iopmp_Memory_Domain_wen         <= 1'b0;
      iopmp_Memory_Domain_Reg_Addr    <= 12'h0;
      iopmp_md_sel                    <= '0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      SRCMD_Update_Valid      <= 1'b0;
      iopmp_Memory_Domain_wen <= 1'b0;

      case (state_q)
        StIdle: begin
          if (cfg.cmd_valid) begin
            op_q     <= cfg.cmd_op;
            data_q   <= cfg.cmd_data;
            cfg_busy <= 1'b1;
            if (cmd_illegal) begin
              state_q       <= StRsp;
              cfg.rsp_valid <= 1'b1;
              cfg.rsp_err   <= 1'b1;
              cfg.rsp_rdata <= 32'h0;
            end else if (cfg.cmd_op == 2'b00) begin
              state_q            <= StSrcLo;
              SRCMD_Update_Valid <= 1'b1;
              SRCMD_MS32bit      <= 1'b0;
              Config_Data        <= cfg.cmd_data[31:0];
              SRCMD_Update_ID    <= {29'h0, cfg.cmd_id};
            end else begin
              state_q                         <= StMdWr;
              iopmp_Memory_Domain_wen         <= 1'b1;
              iopmp_md_sel                    <= MD_NUM'(1) << cfg.cmd_md_idx;
              iopmp_Memory_Domain_Reg_Addr    <= cfg.cmd_reg_addr;
              iopmp_update_Memory_Domain_data <= cfg.cmd_data[31:0];
            end
          end
        end

        StSrcLo: begin
          state_q            <= StSrcHi;
          SRCMD_Update_Valid <= 1'b1;
          SRCMD_MS32bit      <= 1'b1;
          Config_Data        <= data_q[63:32];
        end

        StSrcHi: begin
          state_q         <= StRsp;
          cfg.rsp_valid   <= 1'b1;
          cfg.rsp_err     <= 1'b0;
          cfg.rsp_rdata   <= 32'h0;
          SRCMD_MS32bit   <= 1'b0;
          Config_Data     <= 32'h0;
          SRCMD_Update_ID <= 32'h0;
        end

        StMdWr: begin
          if (op_q == 2'b10) begin
            // Keep select and address up so the checker's read-back path stays valid.
            state_q    <= StMdWait;
            wait_cnt_q <= 4'(VERIFY_LAT - 1);
          end else begin
            state_q                         <= StRsp;
            cfg.rsp_valid                   <= 1'b1;
            cfg.rsp_err                     <= 1'b0;
            cfg.rsp_rdata                   <= 32'h0;
            iopmp_md_sel                    <= '0;
            iopmp_Memory_Domain_Reg_Addr    <= 12'h0;
            iopmp_update_Memory_Domain_data <= 32'h0;
          end
        end

        StMdWait: begin
          if (wait_cnt_q == 4'h0) begin
            state_q <= StMdChk;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'h1;
          end
        end

        StMdChk: begin
          state_q                         <= StRsp;
          cfg.rsp_valid                   <= 1'b1;
          cfg.rsp_rdata                   <= iopmp_entry_data;
          cfg.rsp_err                     <= (iopmp_entry_data != data_q[31:0]);
          iopmp_md_sel                    <= '0;
          iopmp_Memory_Domain_Reg_Addr    <= 12'h0;
          iopmp_update_Memory_Domain_data <= 32'h0;
        end

        StRsp: begin
          if (cfg.rsp_ready) begin
            state_q       <= StIdle;
            cfg.rsp_valid <= 1'b0;
            cfg.rsp_err   <= 1'b0;
            cfg.rsp_rdata <= 32'h0;
            cfg_busy      <= 1'b0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iopmp_cfg_master.sv
// Directed bench for iopmp_cfg_master with a small SRCMD / memory-domain checker model.
module tb_iopmp_cfg_master;
  localparam int unsigned MdNum = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iopmp_cfg_master_if cfg_if ();

  logic             cfg_busy;
  logic [31:0]      srcmd_id;
  logic             srcmd_valid;
  logic             srcmd_ms;
  logic [31:0]      config_data;
  logic [31:0]      md_data;
  logic             md_wen;
  logic [11:0]      md_addr;
  logic [MdNum-1:0] md_sel;
  logic [31:0]      entry_data;

  iopmp_cfg_master #(
    .SRCMD_NUM (2),
    .MD_NUM    (MdNum),
    .VERIFY_LAT(2)
  ) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .cfg                            (cfg_if),
    .cfg_busy                       (cfg_busy),
    .SRCMD_Update_ID                (srcmd_id),
    .SRCMD_Update_Valid             (srcmd_valid),
    .SRCMD_MS32bit                  (srcmd_ms),
    .Config_Data                    (config_data),
    .iopmp_update_Memory_Domain_data(md_data),
    .iopmp_Memory_Domain_wen        (md_wen),
    .iopmp_Memory_Domain_Reg_Addr   (md_addr),
    .iopmp_md_sel                   (md_sel),
    .iopmp_entry_data               (entry_data)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  id;
    logic [1:0]  md;
    logic [11:0] addr;
    logic [63:0] data;
    bit          corrupt;
    int          lat;
    bit          err;
    logic [31:0] rdata;
    int          s_str;
    int          m_str;
    logic [2:0]  sel;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Checker model
  logic [63:0] srcmd_model [2];
  logic [31:0] md_model [MdNum];
  bit          corrupt;
  int          s_cnt, m_cnt, overlap_cnt;
  logic [2:0]  last_sel;
  logic [11:0] last_addr;

  always_comb begin
    entry_data = 32'h0;
    for (int i = 0; i < int'(MdNum); i++) if (md_sel[i]) entry_data = md_model[i];
    if (corrupt) entry_data = 32'h0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      srcmd_model[0] = 64'h0;
      srcmd_model[1] = 64'h0;
    end else begin
      if (srcmd_valid) begin
        s_cnt++;
        if (srcmd_ms) srcmd_model[srcmd_id[0]][63:32] = config_data;
        else          srcmd_model[srcmd_id[0]][31:0]  = config_data;
      end
      if (md_wen) begin
        m_cnt++;
        last_sel  = md_sel;
        last_addr = md_addr;
        for (int i = 0; i < int'(MdNum); i++) if (md_sel[i]) md_model[i] = md_data;
      end
      if (srcmd_valid && md_wen) overlap_cnt++;
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {11'h0, cfg_if.rsp_valid, cfg_if.rsp_err, cfg_if.rsp_rdata, cfg_busy, srcmd_id,
            srcmd_valid, srcmd_ms, config_data, md_data, md_wen, md_addr, md_sel};
  endfunction

  task automatic drive(input vec_t c);
    cfg_if.cmd_op       = c.op;
    cfg_if.cmd_id       = c.id;
    cfg_if.cmd_md_idx   = c.md;
    cfg_if.cmd_reg_addr = c.addr;
    cfg_if.cmd_data     = c.data;
    cfg_if.cmd_valid    = 1'b1;
  endtask

  // Offer a command at posedge+1; lat counts edges from the accepting edge to rsp_valid.
  task automatic run_cmd(input vec_t c, output int lat);
    drive(c);
    @(posedge clk); #1;
    cfg_if.cmd_valid = 1'b0;
    lat = 1;
    while (!cfg_if.rsp_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    cfg_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    cfg_if.rsp_ready = 1'b0;
  endtask

  vec_t vecs [9];
  vec_t c;
  int   lat;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 3'd1, 2'd0, 12'h000, 64'h0000_0005_0000_0003, 1'b0, 3, 1'b0, 32'h0,
                2, 0, 3'b000};
    vecs[1] = '{2'b00, 3'd0, 2'd0, 12'h000, 64'hDEAD_BEEF_1234_5678, 1'b0, 3, 1'b0, 32'h0,
                2, 0, 3'b000};
    vecs[2] = '{2'b01, 3'd0, 2'd2, 12'h3B0, 64'h0000_0000_8000_1000, 1'b0, 2, 1'b0, 32'h0,
                0, 1, 3'b100};
    vecs[3] = '{2'b10, 3'd0, 2'd2, 12'h3B0, 64'h0000_0000_8000_1000, 1'b0, 5, 1'b0,
                32'h8000_1000, 0, 1, 3'b100};
    vecs[4] = '{2'b10, 3'd0, 2'd1, 12'h010, 64'h0000_0000_0000_00AA, 1'b1, 5, 1'b1, 32'h0,
                0, 1, 3'b010};
    vecs[5] = '{2'b11, 3'd0, 2'd0, 12'h000, 64'h1, 1'b0, 1, 1'b1, 32'h0, 0, 0, 3'b000};
    vecs[6] = '{2'b00, 3'd2, 2'd0, 12'h000, 64'h2, 1'b0, 1, 1'b1, 32'h0, 0, 0, 3'b000};
    vecs[7] = '{2'b01, 3'd0, 2'd3, 12'h044, 64'h3, 1'b0, 1, 1'b1, 32'h0, 0, 0, 3'b000};
    vecs[8] = '{2'b01, 3'd0, 2'd0, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 1'b0, 32'h0,
                0, 1, 3'b001};

    cfg_if.cmd_valid    = 1'b0;
    cfg_if.cmd_op       = 2'b00;
    cfg_if.cmd_id       = 3'd0;
    cfg_if.cmd_md_idx   = 2'd0;
    cfg_if.cmd_reg_addr = 12'h0;
    cfg_if.cmd_data     = 64'h0;
    cfg_if.rsp_ready    = 1'b0;
    corrupt     = 1'b0;
    s_cnt       = 0;
    m_cnt       = 0;
    overlap_cnt = 0;
    last_sel    = 3'b000;
    last_addr   = 12'h0;
    for (int i = 0; i < int'(MdNum); i++) md_model[i] = 32'h0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 160'h0);
    check("reset_cmd_ready", cfg_if.cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    check("post_reset_cmd_ready", cfg_if.cmd_ready, 1);
    check("post_reset_outs", all_outs(), 160'h0);
    @(posedge clk); #1;

    // SRCMD beat-by-beat
    c = vecs[0];
    drive(c);
    @(posedge clk); #1;
    cfg_if.cmd_valid = 1'b0;
    check("srcmd_lo_beat", {srcmd_valid, srcmd_ms, config_data, srcmd_id},
          {1'b1, 1'b0, 32'h3, 32'h1});
    check("srcmd_lo_busy", {cfg_busy, cfg_if.cmd_ready, cfg_if.rsp_valid}, 3'b100);
    @(posedge clk); #1;
    check("srcmd_hi_beat", {srcmd_valid, srcmd_ms, config_data, srcmd_id},
          {1'b1, 1'b1, 32'h5, 32'h1});
    @(posedge clk); #1;
    check("srcmd_rsp", {cfg_if.rsp_valid, cfg_if.rsp_err, cfg_if.rsp_rdata}, {2'b10, 32'h0});
    check("srcmd_rsp_idle_outs", {srcmd_valid, srcmd_ms, config_data, srcmd_id}, 66'h0);
    check("srcmd_model_1", srcmd_model[1], 64'h0000_0005_0000_0003);
    handshake();

    // Backpressure with a second command held on the port
    s_cnt = 0;
    c = vecs[8];
    c.addr = 12'h020;
    c.data = 64'h11;
    drive(c);
    @(posedge clk); #1;
    c = vecs[1];
    c.data = 64'hAAAA_BBBB_CCCC_DDDD;
    drive(c);
    @(posedge clk); #1;
    check("bp_rsp_valid", cfg_if.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_%0d", i),
            {cfg_if.cmd_ready, cfg_if.rsp_valid, cfg_busy, cfg_if.rsp_err, cfg_if.rsp_rdata},
            {4'b0110, 32'h0});
    end
    check("bp_no_second_start", s_cnt, 0);
    handshake();
    check("bp_after_hs", {cfg_if.cmd_ready, cfg_busy, cfg_if.rsp_valid}, 3'b100);
    @(posedge clk); #1;
    cfg_if.cmd_valid = 1'b0;
    check("bp_next_accept", {srcmd_valid, srcmd_ms, cfg_busy, cfg_if.cmd_ready}, 4'b1010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_next_rsp", cfg_if.rsp_valid, 1);
    handshake();
    check("bp_next_model", srcmd_model[0], 64'hAAAA_BBBB_CCCC_DDDD);

    // Table of commands
    for (int v = 0; v < 9; v++) begin
      corrupt = vecs[v].corrupt;
      s_cnt = 0;
      m_cnt = 0;
      run_cmd(vecs[v], lat);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_err", v), cfg_if.rsp_err, vecs[v].err);
      check($sformatf("v%0d_rdata", v), cfg_if.rsp_rdata, vecs[v].rdata);
      check($sformatf("v%0d_busy", v), {cfg_busy, cfg_if.cmd_ready}, 2'b10);
      check($sformatf("v%0d_strobes", v), {s_cnt[7:0], m_cnt[7:0]},
            {8'(vecs[v].s_str), 8'(vecs[v].m_str)});
      if (vecs[v].m_str != 0)
        check($sformatf("v%0d_md_sel_addr", v), {last_sel, last_addr},
              {vecs[v].sel, vecs[v].addr});
      if (vecs[v].op == 2'b00 && !vecs[v].err)
        check($sformatf("v%0d_srcmd_model", v), srcmd_model[vecs[v].id[0]], vecs[v].data);
      // Response must stay put for another cycle without rsp_ready
      @(posedge clk); #1;
      check($sformatf("v%0d_rsp_stable", v),
            {cfg_if.rsp_valid, cfg_if.rsp_err, cfg_if.rsp_rdata},
            {1'b1, vecs[v].err, vecs[v].rdata});
      handshake();
      check($sformatf("v%0d_after_hs", v), {cfg_busy, cfg_if.rsp_valid, cfg_if.cmd_ready},
            3'b001);
      corrupt = 1'b0;
    end

    // Reset while the high SRCMD half is on the bus
    c = vecs[0];
    drive(c);
    @(posedge clk); #1;
    cfg_if.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_in_src_hi", {srcmd_valid, srcmd_ms}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", all_outs(), 160'h0);
    check("mid_rst_cmd_ready", cfg_if.cmd_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_recover_ready", cfg_if.cmd_ready, 1);
    run_cmd(vecs[2], lat);
    check("mid_rst_recover_latency", lat, 2);
    handshake();

    check("strobe_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iopmp_cfg_master.md
Name: iopmp_cfg_master

Overview:
- Configuration initiator that programs the IOPMP checker on behalf of the TEE CPU.
- Accepts one command at a time over a valid/ready port. Each command is one of: a 64-bit SRCMD update, or a single memory-domain register write with optional read-back verify.
- Turns each command into the checker's write sequence: two SRCMD half-word beats, or one MD write strobe.
- Returns a status response and raises cfg_busy so the fabric can stall DMA traffic while programming is in progress.

Parameters:
SRCMD_NUM, 2, number of SRCMD entries; a legal cmd_id is below this value
MD_NUM, 4, number of memory domains; one-hot select width
VERIFY_LAT, 2, wait cycles between the MD write strobe and read-back sampling (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 SRCMD write, 01 MD write, 10 MD write+verify, 11 reserved
cmd_id  in  3  SRCMD index (op 00)
cmd_md_idx  in  2  memory-domain index (op 01/10)
cmd_reg_addr  in  12  MD register address (op 01/10)
cmd_data  in  64  write data; op 01/10 use [31:0]
rsp_valid  out  1  response pending
rsp_ready  in  1  response consumed
rsp_err  out  1  1 = illegal op/index or verify mismatch
rsp_rdata  out  32  sampled read-back (op 10), else 0
cfg_busy  out  1  high from accept until response consumed
SRCMD_Update_ID  out  32  zero-extended cmd_id
SRCMD_Update_Valid  out  1  SRCMD write strobe
SRCMD_MS32bit  out  1  0 = low half, 1 = high half
Config_Data  out  32  SRCMD half-word data
iopmp_update_Memory_Domain_data  out  32  MD write data
iopmp_Memory_Domain_wen  out  1  MD write strobe
iopmp_Memory_Domain_Reg_Addr  out  12  MD register address
iopmp_md_sel  out  MD_NUM  one-hot domain select
iopmp_entry_data  in  32  read-back data from the selected domain (combinational in the checker)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset puts every output and the FSM at 0/IDLE.
- Registered outputs: all outputs are registered except cmd_ready.
- cmd_ready: equals (state==IDLE) && rst_n.
- States: IDLE, SRC_LO, SRC_HI, MD_WR, MD_WAIT, MD_CHK, RSP.
- Accept (IDLE, valid&ready): latch the command and set cfg_busy=1.
  - Illegal op (11), cmd_id>=SRCMD_NUM, or cmd_md_idx>=MD_NUM: go to RSP with rsp_err=1 and issue no checker write.
  - op 00: go to SRC_LO.
  - op 01/10: go to MD_WR.
- SRC_LO (1 cycle): SRCMD_Update_Valid=1, MS32bit=0, Config_Data=data[31:0], ID=cmd_id. Next state SRC_HI.
- SRC_HI (1 cycle): Valid=1, MS32bit=1, Config_Data=data[63:32]. Next state RSP.
- MD_WR (1 cycle): wen=1, md_sel=1<<cmd_md_idx, Reg_Addr and MD data driven.
  - op 01: next state RSP.
  - op 10: next state MD_WAIT.
- MD_WAIT: wen=0, md_sel and Reg_Addr held. Counter runs VERIFY_LAT cycles, then MD_CHK.
- MD_CHK (1 cycle): sample iopmp_entry_data into rsp_rdata. rsp_err = (sample != data[31:0]). Next state RSP.
- RSP:
  - rsp_valid=1 from the first RSP cycle; response fields are stable until handshake.
  - On rsp_valid&rsp_ready: clear rsp_valid and cfg_busy, go to IDLE. The next command can be accepted the cycle after.
- Checker outputs outside their strobe states:
  - Valid, wen and md_sel are 0.
  - Data, ID and Reg_Addr return to 0 in IDLE/RSP.
  - Never more than one strobe in a cycle; SRCMD and MD strobes never overlap.
- Latency from accept to rsp_valid:
  - SRCMD: 3 cycles.
  - MD write: 2 cycles.
  - Verify: 3+VERIFY_LAT cycles.
  - Illegal command: 1 cycle.
- cmd_valid while busy: ignored, not dropped. The initiator must hold it.
- Reset mid-sequence: an SRCMD half-written (only SRC_LO issued) is abandoned. Reset clears the checker's SRCMD too, so no partial state persists.

Test Plan:
- Reset: hold rst_n low, then release → all outputs 0; cmd_ready=1 after reset deasserts; no strobes.
- SRCMD write: op00, id=1, data=0x0000_0005_0000_0003 → cycle+1: Valid=1, MS=0, Config_Data=3, ID=1; cycle+2: MS=1, Config_Data=5; cycle+3: rsp_valid=1, err=0; the checker's SRCMD[1] reads 0x5_0000_0003.
- MD write: op01, md_idx=2, reg_addr=0x3B0, data=0x8000_1000 → a single cycle with wen=1, md_sel=4'b0100, Reg_Addr=0x3B0, data=0x80001000; then rsp err=0, rdata=0.
- Verify pass/fail:
  - op10 with VERIFY_LAT=2, entry_data model returning 0x8000_1000 → rsp err=0, rdata=0x80001000.
  - Model returning 0x0 → err=1, rdata=0.
- Illegal commands: op11, or op00 with id=2, or op01 with md_idx=3 when MD_NUM=3 → no strobe on any checker output, rsp_valid 1 cycle after accept, err=1.
- Backpressure and reset mid-sequence:
  - Hold rsp_ready=0 for 5 cycles with cmd_valid held → cmd_ready stays 0, response stable, cfg_busy stays 1; the next command is accepted the cycle after the handshake.
  - Assert rst_n low during SRC_HI → all outputs 0 immediately.
